// File: rtl/traffic_uart_pkg.sv
// Shared types and ASCII constants for the traffic controller UART reporting path.
package traffic_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitBusy,
    StWaitDone
  } arb_state_t;

  localparam logic [7:0] AsciiC     = 8'h43;
  localparam logic [7:0] AsciiN     = 8'h4E;
  localparam logic [7:0] AsciiS     = 8'h53;
  localparam logic [7:0] AsciiE     = 8'h45;
  localparam logic [7:0] AsciiW     = 8'h57;
  localparam logic [7:0] AsciiDigit = 8'h30;

  // Requester lanes wired up at top level.
  localparam int unsigned ReqStatus = 0;
  localparam int unsigned ReqEmerg  = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic                    any
);

  localparam int unsigned PtrW = $clog2(NREQ);

  logic [PtrW-1:0] idx;

  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PtrW'((32'(ptr) + i) % NREQ);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among message sources; holds the grant for a
// whole message and supervises the start/busy handshake with a watchdog and length cap.
module uart_tx_arbiter
  import traffic_uart_pkg::*;
#(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned MAX_MSG_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [NREQ-1:0]   msg_done,
  output logic              err_timeout,
  output logic              err_len
);

  localparam int unsigned PtrW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(MAX_MSG_LEN + 1);
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYC + 1);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PtrW-1:0] owner_q, owner_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic            last_q, last_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [NREQ-1:0] msg_done_q, msg_done_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_len_q, err_len_d;

  logic [NREQ-1:0] pick_gnt;
  logic            pick_any;
  logic [PtrW-1:0] pick_idx;
  logic [PtrW-1:0] next_ptr;
  logic [7:0]      lanes [NREQ];

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .req(req_valid),
    .ptr(rr_ptr_q),
    .gnt(pick_gnt),
    .any(pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      lanes[i] = req_data[8*i +: 8];
      if (pick_gnt[i]) pick_idx = PtrW'(i);
    end
  end

  assign next_ptr = (owner_q == PtrW'(NREQ - 1)) ? '0 : owner_q + PtrW'(1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    byte_cnt_d    = byte_cnt_q;
    wd_d          = wd_q;
    last_d        = last_q;
    tx_data_d     = tx_data_q;
    msg_done_d    = '0;
    err_timeout_d = 1'b0;
    err_len_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A byte still on the wire (e.g. from before a reset) must finish first.
        if (pick_any && !tx_busy) begin
          grant_d    = pick_gnt;
          owner_d    = pick_idx;
          byte_cnt_d = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (req_valid[owner_q]) begin
          tx_data_d  = lanes[owner_q];
          last_d     = req_last[owner_q];
          byte_cnt_d = byte_cnt_q + CntW'(1);
          state_d    = StStart;
        end
      end
      StStart: begin
        wd_d    = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (wd_q == WdW'(TIMEOUT_CYC - 1)) begin
          err_timeout_d = 1'b1;
          grant_d       = '0;
          rr_ptr_d      = next_ptr;
          state_d       = StIdle;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (last_q) begin
            msg_done_d = grant_q;
            grant_d    = '0;
            rr_ptr_d   = next_ptr;
            state_d    = StIdle;
          end else if (byte_cnt_q == CntW'(MAX_MSG_LEN)) begin
            // Remaining bytes are left with the requester and compete again as a new message.
            err_len_d = 1'b1;
            grant_d   = '0;
            rr_ptr_d  = next_ptr;
            state_d   = StIdle;
          end else begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      byte_cnt_q    <= '0;
      wd_q          <= '0;
      last_q        <= 1'b0;
      tx_data_q     <= 8'h00;
      msg_done_q    <= '0;
      err_timeout_q <= 1'b0;
      err_len_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      byte_cnt_q    <= byte_cnt_d;
      wd_q          <= wd_d;
      last_q        <= last_d;
      tx_data_q     <= tx_data_d;
      msg_done_q    <= msg_done_d;
      err_timeout_q <= err_timeout_d;
      err_len_q     <= err_len_d;
    end
  end

  assign grant       = grant_q;
  assign req_ready   = grant_q & {NREQ{state_q == StLoad}};
  assign tx_start    = (state_q == StStart);
  assign tx_data     = tx_data_q;
  assign msg_done    = msg_done_q;
  assign err_timeout = err_timeout_q;
  assign err_len     = err_len_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural uart_tx busy model.
module tb_uart_tx_arbiter;

  localparam int BusyLen = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic [2:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [2:0]  msg_done;
  logic        err_timeout;
  logic        err_len;

  logic model_en;
  logic force_busy;
  int   busy_cnt = 0;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx_arbiter #(
    .NREQ       (3),
    .TIMEOUT_CYC(16),
    .MAX_MSG_LEN(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .grant      (grant),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .msg_done   (msg_done),
    .err_timeout(err_timeout),
    .err_len    (err_len)
  );

  always #10 clk = ~clk;

  // uart_tx stand-in: samples start at the edge ending START, busy for BusyLen cycles.
  always @(posedge clk) begin
    if (model_en && tx_start) busy_cnt <= BusyLen;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy | (busy_cnt != 0);

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  last;
    logic [23:0] data;
    logic [2:0]  exp_grant;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < 200);
    check(name, 32'(tx_start), 32'd1);
  endtask

  task automatic wait_pulse(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((|msg_done) || err_timeout || err_len) && n < 200);
    check(name, 32'((|msg_done) || err_timeout || err_len), 32'd1);
  endtask

  initial begin
    int   n;
    logic flag;

    // All lanes: 2='S', 1='E', 0='C'. rr_ptr trace: 0->1->2->0->1->0->2->1->1
    vecs[0] = '{valid: 3'b111, last: 3'b111, data: 24'h534543, exp_grant: 3'b001, exp_data: 8'h43};
    vecs[1] = '{valid: 3'b111, last: 3'b111, data: 24'h534543, exp_grant: 3'b010, exp_data: 8'h45};
    vecs[2] = '{valid: 3'b111, last: 3'b111, data: 24'h534543, exp_grant: 3'b100, exp_data: 8'h53};
    vecs[3] = '{valid: 3'b111, last: 3'b111, data: 24'h534543, exp_grant: 3'b001, exp_data: 8'h43};
    vecs[4] = '{valid: 3'b101, last: 3'b111, data: 24'h534543, exp_grant: 3'b100, exp_data: 8'h53};
    vecs[5] = '{valid: 3'b110, last: 3'b111, data: 24'h534543, exp_grant: 3'b010, exp_data: 8'h45};
    vecs[6] = '{valid: 3'b011, last: 3'b111, data: 24'h534543, exp_grant: 3'b001, exp_data: 8'h43};
    vecs[7] = '{valid: 3'b001, last: 3'b111, data: 24'h534543, exp_grant: 3'b001, exp_data: 8'h43};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    model_en   = 1'b1;
    force_busy = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_done", 32'(msg_done), 32'd0);
    check("rst_errs", 32'({err_timeout, err_len}), 32'd0);
    rst_n = 1'b1;

    // Round-robin table, one 1-byte message per entry
    for (int i = 0; i < 8; i++) begin
      req_valid = vecs[i].valid;
      req_last  = vecs[i].last;
      req_data  = vecs[i].data;
      wait_start($sformatf("rr%0d_start", i));
      check($sformatf("rr%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("rr%0d_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
      wait_pulse($sformatf("rr%0d_pulse", i));
      check($sformatf("rr%0d_done", i), 32'(msg_done), 32'(vecs[i].exp_grant));
    end
    req_valid = '0;

    // Single two-byte message 'N','9' from requester 0
    req_data  = 24'h00004E;
    req_last  = 3'b000;
    req_valid = 3'b001;
    wait_start("msg_start0");
    check("msg_data0", 32'(tx_data), 32'h4E);
    check("msg_grant", 32'(grant), 32'b001);
    req_data = 24'h000039;
    req_last = 3'b001;
    wait_start("msg_start1");
    check("msg_data1", 32'(tx_data), 32'h39);
    req_valid = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_busy && n < 50);
    check("msg_done_early", 32'(msg_done), 32'd0);
    @(negedge clk);
    check("msg_done", 32'(msg_done), 32'b001);
    check("msg_release", 32'(grant), 32'd0);

    // Busy at idle: no grant while tx_busy, grant one cycle after it falls
    force_busy = 1'b1;
    req_data   = 24'h005700;
    req_last   = 3'b010;
    req_valid  = 3'b010;
    flag       = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (grant != 3'b000) flag = 1'b1;
    end
    check("busy_idle_hold", 32'(flag), 32'd0);
    force_busy = 1'b0;
    @(negedge clk);
    check("busy_idle_grant", 32'(grant), 32'b010);
    wait_pulse("busy_idle_pulse");
    check("busy_idle_done", 32'(msg_done), 32'b010);
    req_valid = '0;

    // Watchdog: busy never rises; 16 WAIT_BUSY cycles then the pulse cycle
    model_en  = 1'b0;
    req_data  = 24'h000043;
    req_last  = 3'b001;
    req_valid = 3'b001;
    wait_start("wd_start");
    check("wd_grant", 32'(grant), 32'b001);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err_timeout && n < 40);
    check("wd_latency", 32'(n), 32'd17);
    check("wd_release", 32'(grant), 32'd0);
    check("wd_no_done", 32'(msg_done), 32'd0);
    model_en  = 1'b1;
    req_data  = 24'h004543;
    req_last  = 3'b011;
    req_valid = 3'b011;
    wait_start("wd_next_start");
    check("wd_next_grant", 32'(grant), 32'b010);
    wait_pulse("wd_next_pulse");
    check("wd_next_done", 32'(msg_done), 32'b010);
    req_valid = '0;

    // Length cap: ten bytes '0'..'9' from requester 1, last only on the tenth
    req_valid = 3'b010;
    for (int k = 0; k < 10; k++) begin
      req_data = {8'h00, 8'h30 + 8'(k), 8'h00};
      req_last = (k == 9) ? 3'b010 : 3'b000;
      wait_start($sformatf("len%0d_start", k));
      check($sformatf("len%0d_data", k), 32'(tx_data), 32'h30 + 32'(k));
      if (k == 8) check("len_regrant", 32'(grant), 32'b010);
      if (k == 7) begin
        wait_pulse("len_cap_pulse");
        check("len_err", 32'(err_len), 32'd1);
        check("len_no_done", 32'(msg_done), 32'd0);
        check("len_release", 32'(grant), 32'd0);
      end
    end
    wait_pulse("len_tail_pulse");
    check("len_tail_done", 32'(msg_done), 32'b010);
    req_valid = '0;

    // Reset during WAIT_DONE; rr_ptr must restart at 0 and no start may overlap busy
    req_data  = 24'h000045;
    req_last  = 3'b001;
    req_valid = 3'b001;
    wait_start("rm_start");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rm_grant", 32'(grant), 32'd0);
    check("rm_ready", 32'(req_ready), 32'd0);
    check("rm_start0", 32'(tx_start), 32'd0);
    check("rm_data", 32'(tx_data), 32'd0);
    check("rm_pulses", 32'({msg_done, err_timeout, err_len}), 32'd0);
    check("rm_busy_still", 32'(tx_busy), 32'd1);
    rst_n     = 1'b1;
    req_data  = 24'h575300;
    req_last  = 3'b110;
    req_valid = 3'b110;
    flag      = 1'b0;
    n         = 0;
    do begin
      @(negedge clk);
      n++;
      if (tx_busy && grant != 3'b000) flag = 1'b1;
    end while (!tx_start && n < 100);
    check("rm_restart", 32'(tx_start), 32'd1);
    check("rm_overlap", 32'(flag), 32'd0);
    check("rm_ptr0_grant", 32'(grant), 32'b010);
    wait_pulse("rm_pulse");
    check("rm_done", 32'(msg_done), 32'b010);
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
